// File: rtl/column.sv
// Single 16-row column of a drop-piece game: rows 0..14 hold pieces, row 15 shows the cursor.
// Define COLUMN_DROP_ANIM_EN to animate each piece falling from row 14; otherwise pieces land in one edge.
module column (
    input  logic        clk,
    input  logic        RST,
    input  logic        player,
    input  logic        placement,
    input  logic        dropping,
    output logic [15:0] RedPixels,
    output logic [15:0] GrnPixels
);

    logic [14:0] r_red;
    logic [14:0] r_grn;
    logic [3:0]  r_height;
    logic        w_full;
    logic [14:0] w_slot;
    logic [14:0] w_fall_red;
    logic [14:0] w_fall_grn;

    assign w_full = (r_height == 4'd15);
    assign w_slot = 15'd1 << r_height;

`ifdef COLUMN_DROP_ANIM_EN
    typedef enum logic {IDLE, FALLING} state_t;

    state_t      r_state;
    logic [3:0]  r_pos;
    logic        r_colour;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_red    <= '0;
            r_grn    <= '0;
            r_height <= '0;
            r_state  <= IDLE;
            r_pos    <= '0;
            r_colour <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (placement && !w_full) begin
                        r_colour <= player;
                        r_pos    <= 4'd14;
                        r_state  <= FALLING;
                    end
                end
                FALLING: begin
                    // Landing happens on the edge the piece already sits on the lowest free row.
                    if (r_pos == r_height) begin
                        if (r_colour)
                            r_grn <= r_grn | w_slot;
                        else
                            r_red <= r_red | w_slot;
                        r_height <= r_height + 4'd1;
                        r_state  <= IDLE;
                    end else begin
                        r_pos <= r_pos - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_fall_red = (r_state == FALLING && !r_colour) ? (15'd1 << r_pos) : '0;
    assign w_fall_grn = (r_state == FALLING &&  r_colour) ? (15'd1 << r_pos) : '0;
`else
    always_ff @(posedge clk) begin
        if (RST) begin
            r_red    <= '0;
            r_grn    <= '0;
            r_height <= '0;
        end else if (placement && !w_full) begin
            if (player)
                r_grn <= r_grn | w_slot;
            else
                r_red <= r_red | w_slot;
            r_height <= r_height + 4'd1;
        end
    end

    assign w_fall_red = '0;
    assign w_fall_grn = '0;
`endif

    assign RedPixels = {dropping & ~player, r_red | w_fall_red};
    assign GrnPixels = {dropping &  player, r_grn | w_fall_grn};

endmodule

// File: tb/tb_column.sv
// Scoreboard bench for column: a driver pushes expected pixels from a cell-array model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_column;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        player = 1'b0;
    logic        placement = 1'b0;
    logic        dropping = 1'b0;
    logic [15:0] RedPixels;
    logic [15:0] GrnPixels;

    column dut (
        .clk(clk),
        .RST(RST),
        .player(player),
        .placement(placement),
        .dropping(dropping),
        .RedPixels(RedPixels),
        .GrnPixels(GrnPixels)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] g;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Model: cell contents 0=empty 1=red 2=green, plus a pending piece counting edges to landing.
    int   m_cell[15];
    int   m_h = 0;
    bit   m_fall = 1'b0;
    int   m_col = 0;
    int   m_wait = 0;

    task automatic model_edge(input bit rst, input bit plc, input bit ply);
        if (rst) begin
            for (int i = 0; i < 15; i++) m_cell[i] = 0;
            m_h = 0;
            m_fall = 1'b0;
            m_wait = 0;
        end else begin
`ifdef COLUMN_DROP_ANIM_EN
            if (m_fall) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_cell[m_h] = m_col;
                    m_h++;
                    m_fall = 1'b0;
                end
            end else if (plc && m_h < 15) begin
                m_fall = 1'b1;
                m_col  = ply ? 2 : 1;
                m_wait = 15 - m_h;
            end
`else
            if (plc && m_h < 15) begin
                m_cell[m_h] = ply ? 2 : 1;
                m_h++;
            end
`endif
        end
    endtask

    task automatic model_out(input bit ply, input bit drp, output logic [15:0] r, output logic [15:0] g);
        int p;
        r = '0;
        g = '0;
        for (int i = 0; i < 15; i++) begin
            if (m_cell[i] == 1) r[i] = 1'b1;
            else if (m_cell[i] == 2) g[i] = 1'b1;
        end
        if (m_fall) begin
            p = m_h + m_wait - 1;
            if (m_col == 1) r[p] = 1'b1;
            else g[p] = 1'b1;
        end
        if (drp) begin
            if (ply) g[15] = 1'b1;
            else r[15] = 1'b1;
        end
    endtask

    // One clock edge of stimulus; expectation comes from the model unless a fixed value is supplied.
    task automatic step(input bit rst, input bit plc, input bit ply, input bit drp,
                        input bit use_c, input logic [15:0] cr, input logic [15:0] cg);
        exp_t e;
        @(negedge clk);
        #2;
        RST = rst;
        placement = plc;
        player = ply;
        dropping = drp;
        @(posedge clk);
        #1;
        model_edge(rst, plc, ply);
        model_out(ply, drp, e.r, e.g);
        if (use_c) begin
            e.r = cr;
            e.g = cg;
        end
        e.id = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while (m_fall && guard < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (RedPixels !== mon_e.r || GrnPixels !== mon_e.g) begin
                errors++;
                $display("FAIL pixels step %0d: got R=%h G=%h, expected R=%h G=%h",
                         mon_e.id, RedPixels, GrnPixels, mon_e.r, mon_e.g);
            end
            checks++;
            if ((RedPixels & GrnPixels) !== 16'h0000) begin
                errors++;
                $display("FAIL overlap step %0d: got R&G=%h, expected 0000", mon_e.id, RedPixels & GrnPixels);
            end
        end
    end

    initial begin
        for (int i = 0; i < 15; i++) m_cell[i] = 0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h8000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 16'h0000);

`ifdef COLUMN_DROP_ANIM_EN
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000);
        for (int k = 13; k >= 0; k--) begin
            logic [15:0] v;
            v = 16'd1 << k;
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v, 16'h0000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000);

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h4000);
        for (int k = 13; k >= 1; k--) begin
            logic [15:0] v;
            v = 16'd1 << k;
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, v);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0002);

        for (int n = 0; n < 13; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            settle();
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7FFD, 16'h0002);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7FFD, 16'h8002);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h4000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h2000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
`else
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000);
        for (int n = 0; n < 12; n++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h7FF8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0007, 16'hFFF8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001);
`endif

        for (int n = 0; n < 3000; n++) begin
            bit rr, pp, yy, dd;
            rr = ($urandom_range(0, 199) == 0);
            pp = ($urandom_range(0, 2) == 0);
            yy = $urandom_range(0, 1) == 1;
            dd = $urandom_range(0, 1) == 1;
            step(rr, pp, yy, dd, 1'b0, '0, '0);
        end

        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
